ft245_rx_ctrl: RTL and testbench
================================

# ft245_rx_ctrl

Receive-side controller for the FT245 asynchronous USB FIFO. It sits between the FT245 pins and the on-chip sample FIFO. It watches RXF#, generates correctly timed RD# strobes, and captures each byte from the data bus. The byte is presented on the simple interface as valid/ready, with a one-entry holding register. The block only reads: the top level keeps the shared data bus undriven toward the FT245.

## Interface
- `RD_LOW_CLKS`, default 8: number of clk cycles RD# is held low (8 × 7.8 ns = 62.5 ns at 128 MHz); must be ≥ 2.
- `RD_HIGH_CLKS`, default 11: minimum number of clk cycles RD# stays high after a read before RXF# is evaluated again; must be ≥ 3.
- `CNT_W`, default 16: width of the received-byte counter.

Ports:
- `clk`  in  1  system clock, 128 MHz.
- `rst`  in  1  reset, synchronous, active-high.
- `rxf_245`  in  1  FT245 RXF#, asynchronous, low = data available.
- `data_245`  in  8  FT245 data bus, read direction only.
- `rx_245`  out  1  FT245 RD#, active low, registered.
- `rx_data_si`  out  8  captured byte.
- `rx_valid_si`  out  1  `rx_data_si` is valid.
- `rx_ready_si`  in  1  consumer accepts the byte.
- `rx_count`  out  `CNT_W`  bytes handed off since reset; wraps modulo 2^`CNT_W`.

## Operation
- `rxf_245` passes through a 2-flop synchronizer to give `rxf_s`. `data_245` is not synchronized: it is sampled only when guaranteed stable.
- The FSM has three states: IDLE, RD_LOW and RD_HIGH. A single down-counter `cnt` is sized to the larger of the two timing parameters.
- **IDLE:** RD# is high. A read starts when `rxf_s == 0` and the holding register is free. "Free" means `!rx_valid_si`, or `rx_valid_si && rx_ready_si` in the same cycle. On a start: go to RD_LOW, drive `rx_245` low, load `cnt = RD_LOW_CLKS-1`.
- **RD_LOW:** decrement `cnt`. When `cnt == 0`:
  - capture `data_245` into the holding register;
  - set `rx_valid_si`;
  - drive `rx_245` high;
  - load `cnt = RD_HIGH_CLKS-1` and go to RD_HIGH.
- **RD_HIGH:** decrement `cnt`. At 0, go to IDLE.
- **Handshake:** a transfer occurs when `rx_valid_si && rx_ready_si` on a rising edge.
  - On a transfer, `rx_valid_si` clears unless a new capture happens in the same cycle.
  - `rx_data_si` is stable while valid is high and not yet accepted.
  - `rx_count` increments once per transfer.
- Backpressure never aborts a read already in progress. A read only starts when space is guaranteed, so no byte is ever dropped.
- A glitch or rise on RXF# during RD_LOW or RD_HIGH is ignored; RXF# is only evaluated in IDLE.
- **Reset, including mid-read:**
  - `rx_245` = 1, `rx_valid_si` = 0, `rx_data_si` = 0x00, `rx_count` = 0, state = IDLE, synchronizer flops = 1.
  - A byte whose strobe is cut short is lost. This is accepted.

## Timing
- RXF# falling edge to `rx_245` low: 3 cycles (2 for synchronization, 1 for the registered start).
- `rx_245` is low for exactly `RD_LOW_CLKS` cycles.
- `rx_valid_si` rises on the same edge that `rx_245` returns high.
- Minimum RD# high time is `RD_HIGH_CLKS` + 1 cycles (the extra cycle is the IDLE decision). This covers the FT245 RD-inactive-to-RXF# delay plus synchronizer latency.
- Peak throughput: one byte every `RD_LOW_CLKS + RD_HIGH_CLKS + 1` cycles (20 cycles, 6.4 MB/s at defaults).

## Structure
- Default timing constants live as defines in the shared include `module_params.v` (`FT245_RD_LOW_CLKS`, `FT245_RD_HIGH_CLKS`).
- State encodings are local parameters inside the block.
- Sub-module `sync_2ff` (parameterised width, reset value) provides the RXF# synchronizer. It is reusable for TXE# later.

## Test plan
1. Reset, then RXF# low with `data_245` = 0xA5 and ready = 1. Expect:
   - `rx_245` low 3 cycles later, for exactly 8 cycles;
   - `rx_valid_si` high for 1 cycle with `rx_data_si` = 0xA5;
   - `rx_count` = 1.
2. RXF# held low, ready = 1, data stepping 0x00..0x0F per strobe. Expect 16 bytes delivered in order, strobe period 20 cycles, `rx_count` = 16.
3. Ready = 0 after the first byte. Expect:
   - valid held with data stable, no second RD# strobe;
   - after ready rises, the next RD# falls no later than 3 cycles after the transfer.
4. Valid and ready high in the same IDLE cycle with RXF# low. Expect a new read to start that cycle, with no bubble beyond the documented timing.
5. Assert `rst` 4 cycles into RD_LOW. Expect on the next edge: `rx_245` = 1, `rx_valid_si` = 0, `rx_count` = 0; after release, the next read is normal.
6. Preload `rx_count` to 0xFFFF by driving 65535 transfers (or via a force), then complete one more transfer. Expect `rx_count` to wrap to 0x0000.

Source files
------------

// File: rtl/ft245_rx_ctrl_pkg.sv
// Shared constants and types for the FT245 receive controller.
package ft245_rx_ctrl_pkg;

  localparam int unsigned FT245_RD_LOW_CLKS  = 8;
  localparam int unsigned FT245_RD_HIGH_CLKS = 11;
  localparam int unsigned FT245_CNT_W        = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_LOW  = 2'd1,
    ST_RD_HIGH = 2'd2
  } rx_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with configurable width and reset value.
module sync_2ff #(
  parameter int unsigned W = 1,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ft245_rx_ctrl.sv
// FT245 receive controller: paced RD# strobes, byte capture, one-entry valid/ready hand-off.
module ft245_rx_ctrl
  import ft245_rx_ctrl_pkg::*;
#(
  parameter int unsigned RD_LOW_CLKS  = FT245_RD_LOW_CLKS,   // >= 2
  parameter int unsigned RD_HIGH_CLKS = FT245_RD_HIGH_CLKS,  // >= 3
  parameter int unsigned CNT_W        = FT245_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rxf_245,
  input  logic [7:0]       data_245,
  output logic             rx_245,
  output logic [7:0]       rx_data_si,
  output logic             rx_valid_si,
  input  logic             rx_ready_si,
  output logic [CNT_W-1:0] rx_count
);

  localparam int unsigned T_MAX = max_u(RD_LOW_CLKS, RD_HIGH_CLKS);
  localparam int unsigned CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  rx_state_e        state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             rx_245_nxt;
  logic             valid_nxt;
  logic [7:0]       data_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             rxf_s;
  logic             xfer;

  sync_2ff #(
    .W       (1),
    .RST_VAL (1'b1)
  ) u_rxf_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxf_245),
    .q   (rxf_s)
  );

  assign xfer = rx_valid_si && rx_ready_si;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rx_245      <= 1'b1;
      rx_valid_si <= 1'b0;
      rx_data_si  <= 8'h00;
      rx_count    <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      rx_245      <= rx_245_nxt;
      rx_valid_si <= valid_nxt;
      rx_data_si  <= data_nxt;
      rx_count    <= count_nxt;
    end
  end

  // Next state; a capture in RD_LOW overrides the hand-off clear of valid.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    rx_245_nxt = rx_245;
    valid_nxt  = rx_valid_si;
    data_nxt   = rx_data_si;
    count_nxt  = rx_count;

    if (xfer) begin
      valid_nxt = 1'b0;
      count_nxt = rx_count + CNT_W'(1);
    end

    case (state)
      ST_IDLE: begin
        // Only start when the holding register is guaranteed free at capture time.
        if (!rxf_s && (!rx_valid_si || xfer)) begin
          state_nxt  = ST_RD_LOW;
          rx_245_nxt = 1'b0;
          cnt_nxt    = CW'(RD_LOW_CLKS - 1);
        end
      end
      ST_RD_LOW: begin
        if (cnt == '0) begin
          data_nxt   = data_245;
          valid_nxt  = 1'b1;
          rx_245_nxt = 1'b1;
          cnt_nxt    = CW'(RD_HIGH_CLKS - 1);
          state_nxt  = ST_RD_HIGH;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ST_RD_HIGH: begin
        if (cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ft245_rx_ctrl.sv
// Bench for ft245_rx_ctrl: FT245 byte-queue model plus a hand-off scoreboard.
module tb_ft245_rx_ctrl;

  localparam int unsigned LOW  = 8;
  localparam int unsigned HIGH = 11;
  localparam int unsigned CW   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          rxf_245;
  logic [7:0]    data_245;
  logic          rx_245;
  logic [7:0]    rx_data_si;
  logic          rx_valid_si;
  logic          rx_ready_si;
  logic [CW-1:0] rx_count;

  ft245_rx_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .rxf_245     (rxf_245),
    .data_245    (data_245),
    .rx_245      (rx_245),
    .rx_data_si  (rx_data_si),
    .rx_valid_si (rx_valid_si),
    .rx_ready_si (rx_ready_si),
    .rx_count    (rx_count)
  );

  always #4 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: bytes waiting in the FT245, bytes captured but not yet handed off.
  logic [7:0]    ft_q[$];
  logic [7:0]    exp_q[$];
  logic [CW-1:0] exp_count;
  int cyc = 0;
  int low_run = 0, high_run = 0;
  int last_fall = -1, last_xfer = -1, rxf_fall_cyc = -1;
  int falls = 0;
  bit have_high = 0, chk_period = 0, lat_arm = 0, wait_xfer = 0, exact_restart = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic update_pins();
    logic nr;
    nr = (ft_q.size() == 0);
    if (lat_arm && rxf_245 === 1'b1 && !nr) begin
      rxf_fall_cyc = cyc;
      lat_arm = 0;
    end
    rxf_245  = nr;
    data_245 = (rx_245 === 1'b0 && ft_q.size() != 0) ? ft_q[0] : 8'($urandom);
  endtask

  // Advance one clock and check everything observable against the model.
  task automatic cycle();
    logic pv, pr, prd, r;
    logic [7:0] pd, b;
    pv = rx_valid_si; pr = rx_ready_si; prd = rx_245; pd = rx_data_si; r = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      if (prd === 1'b0 && ft_q.size() != 0) void'(ft_q.pop_front());
      exp_q.delete();
      exp_count = '0;
      have_high = 0; low_run = 0; last_fall = -1;
      chk("rst_rd", rx_245, 1);
      chk("rst_valid", rx_valid_si, 0);
      chk("rst_data", rx_data_si, 8'h00);
      chk("rst_count", rx_count, 0);
    end else begin
      if (pv && pr) begin
        chk("xfer_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("xfer_data", pd, exp_q.pop_front());
        exp_count++;
        last_xfer = cyc;
      end
      if (pv && !pr) begin
        chk("hold_valid", rx_valid_si, 1);
        chk("hold_data", rx_data_si, pd);
      end
      if (prd && !rx_245) begin
        falls++;
        if (have_high) chk("rd_high_min", high_run >= int'(HIGH + 1), 1);
        if (rxf_fall_cyc >= 0) begin
          chk("start_latency", cyc - rxf_fall_cyc, 3);
          rxf_fall_cyc = -1;
        end
        if (chk_period && last_fall >= 0) chk("strobe_period", cyc - last_fall, LOW + HIGH + 1);
        if (wait_xfer) begin
          chk("restart_after_xfer", (cyc - last_xfer) <= 3, 1);
          wait_xfer = 0;
        end
        if (exact_restart) begin
          chk("same_cycle_restart", cyc - last_xfer, 0);
          exact_restart = 0;
        end
        last_fall = cyc;
        low_run = 0;
      end
      if (!prd && rx_245) begin
        chk("rd_low_width", low_run, LOW);
        chk("ft_nonempty", ft_q.size() != 0, 1);
        b = (ft_q.size() != 0) ? ft_q.pop_front() : 8'h00;
        exp_q.push_back(b);
        chk("valid_on_rise", rx_valid_si, 1);
        chk("capture_data", rx_data_si, b);
        high_run = 0;
        have_high = 1;
      end
      if (!rx_245) low_run++; else high_run++;
      chk("count", rx_count, exp_count);
      chk("valid_model", rx_valid_si, exp_q.size() != 0);
      chk("no_overrun", exp_q.size() <= 1, 1);
    end
    update_pins();
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while ((ft_q.size() != 0 || exp_q.size() != 0 || rx_245 !== 1'b1) && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, n < budget, 1);
    repeat (HIGH + 3) cycle();
  endtask

  initial begin
    int n;
    rst = 1'b1; rxf_245 = 1'b1; data_245 = 8'h00; rx_ready_si = 1'b0;
    exp_count = '0;
    repeat (3) cycle();
    rst = 1'b0;
    repeat (4) cycle();

    // 1: single byte, latency and strobe width
    rx_ready_si = 1'b1;
    lat_arm = 1;
    ft_q.push_back(8'hA5);
    update_pins();
    wait_drain(100, "t1_drain");
    chk("t1_count", rx_count, 1);
    chk("t1_latency_seen", rxf_fall_cyc, -1);

    // 2: back-to-back stream at peak rate
    last_fall = -1;
    chk_period = 1;
    for (int i = 0; i < 16; i++) ft_q.push_back(8'(i));
    update_pins();
    wait_drain(600, "t2_drain");
    chk_period = 0;
    chk("t2_count", rx_count, 17);

    // 3: backpressure holds the byte and blocks further strobes
    rx_ready_si = 1'b0;
    n = falls;
    ft_q.push_back(8'($urandom));
    ft_q.push_back(8'($urandom));
    update_pins();
    repeat (60) cycle();
    chk("t3_one_strobe", falls - n, 1);
    chk("t3_valid_held", rx_valid_si, 1);
    rx_ready_si = 1'b1;
    wait_xfer = 1;
    wait_drain(200, "t3_drain");
    chk("t3_restart_seen", wait_xfer, 0);
    chk("t3_count", rx_count, 19);

    // 4: accept in an idle cycle starts the next read on that same edge
    rx_ready_si = 1'b0;
    ft_q.push_back(8'($urandom));
    ft_q.push_back(8'($urandom));
    update_pins();
    n = 0;
    while (rx_valid_si !== 1'b1 && n < 100) begin cycle(); n++; end
    chk("t4_valid_wait", n < 100, 1);
    repeat ($urandom_range(15, 40)) cycle();
    rx_ready_si = 1'b1;
    exact_restart = 1;
    wait_drain(200, "t4_drain");
    chk("t4_restart_seen", exact_restart, 0);
    chk("t4_count", rx_count, 21);

    // 5: reset four cycles into RD_LOW, then a clean read
    ft_q.push_back(8'($urandom));
    ft_q.push_back(8'h3C);
    update_pins();
    n = 0;
    while (rx_245 !== 1'b0 && n < 50) begin cycle(); n++; end
    chk("t5_fall_wait", n < 50, 1);
    repeat (4) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    rxf_fall_cyc = cyc;
    wait_drain(100, "t5_drain");
    chk("t5_count", rx_count, 1);

    // 6: random data with random backpressure
    for (int i = 0; i < 40; i++) ft_q.push_back(8'($urandom));
    update_pins();
    n = 0;
    while ((ft_q.size() != 0 || exp_q.size() != 0) && n < 4000) begin
      rx_ready_si = 1'($urandom_range(0, 1));
      cycle();
      n++;
    end
    chk("t6_random_drain", n < 4000, 1);
    rx_ready_si = 1'b1;
    wait_drain(100, "t6_settle");
    chk("t6_count", rx_count, 41);

    // 7: counter wrap
    force dut.rx_count = 16'hFFFF;
    #1;
    release dut.rx_count;
    exp_count = 16'hFFFF;
    cycle();
    chk("t7_preload", rx_count, 16'hFFFF);
    ft_q.push_back(8'($urandom));
    update_pins();
    wait_drain(100, "t7_drain");
    chk("t7_wrap", rx_count, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
